// File: rtl/calculator_core.sv
// calculator_core: handshaked 8-function unsigned calculator.
//
// Accepts one operation per valid/ready transaction and returns a registered
// result on a valid/ready output channel that honours backpressure.
// add/sub/mul/logic ops complete in one cycle. div/mod iterate one restoring
// step per cycle, so the result appears DATA_W+1 cycles after accept.
// Divide-by-zero returns all ones with err_out set.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid, in_ready       request handshake
//   dat_a_in, dat_b_in       unsigned operands (DATA_W bits)
//   function_in              opcode: add sub mul div mod and or xor
//   out_valid, out_ready     result handshake
//   out                      result (OUT_W = 2*DATA_W bits)
//   err_out                  divide-by-zero flag, qualified by out_valid
//   busy                     high while computing or holding a result
module calculator_core #(
    parameter int unsigned  DATA_W = 8,
    localparam int unsigned OUT_W  = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dat_a_in,
    input  logic [DATA_W-1:0] dat_b_in,
    input  logic [2:0]        function_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out,
    output logic              err_out,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b010;
    localparam logic [2:0] OpDiv = 3'b011;
    localparam logic [2:0] OpMod = 3'b100;
    localparam logic [2:0] OpAnd = 3'b101;
    localparam logic [2:0] OpOr  = 3'b110;
    localparam logic [2:0] OpXor = 3'b111;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              is_mod_q, is_mod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [OUT_W-1:0]  a_ext, b_ext, alu_res;
    logic              is_divmod;
    logic [DATA_W:0]   rem_shift, rem_trial;
    logic              step_ge;
    logic [DATA_W-1:0] rem_step, quo_step;

    // Single-cycle operations, computed straight from the request inputs.
    always_comb begin
        a_ext   = OUT_W'(dat_a_in);
        b_ext   = OUT_W'(dat_b_in);
        alu_res = '0;
        unique case (function_in)
            OpAdd:   alu_res = a_ext + b_ext;
            OpSub:   alu_res = a_ext - b_ext;
            OpMul:   alu_res = a_ext * b_ext;
            OpAnd:   alu_res = a_ext & b_ext;
            OpOr:    alu_res = a_ext | b_ext;
            OpXor:   alu_res = a_ext ^ b_ext;
            default: alu_res = '0;
        endcase
    end

    assign is_divmod = (function_in == OpDiv) || (function_in == OpMod);

    // One restoring step: shift the next dividend bit (quotient MSB) into the
    // remainder and subtract the divisor if it fits. The partial remainder is
    // always below the divisor, so the trial difference lies in
    // [-divisor, divisor-1] and its top bit is a clean borrow indicator.
    always_comb begin
        rem_shift = {rem_q, quo_q[DATA_W-1]};
        rem_trial = rem_shift - {1'b0, dvs_q};
        step_ge   = ~rem_trial[DATA_W];
        rem_step  = step_ge ? rem_trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];
        quo_step  = {quo_q[DATA_W-2:0], step_ge};
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        err_d    = err_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_mod_d = is_mod_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    err_d = 1'b0;
                    if (is_divmod) begin
                        if (dat_b_in == '0) begin
                            out_d   = '1;
                            err_d   = 1'b1;
                            state_d = StDone;
                        end else begin
                            // Quotient register starts as the dividend and is
                            // shifted out MSB first as quotient bits shift in.
                            rem_d    = '0;
                            quo_d    = dat_a_in;
                            dvs_d    = dat_b_in;
                            is_mod_d = (function_in == OpMod);
                            cnt_d    = CNT_W'(DATA_W);
                            state_d  = StCalc;
                        end
                    end else begin
                        out_d   = alu_res;
                        state_d = StDone;
                    end
                end
            end
            StCalc: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_d   = is_mod_q ? OUT_W'(rem_step) : OUT_W'(quo_step);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            out_q    <= '0;
            err_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_mod_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            err_q    <= err_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_mod_q <= is_mod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StCalc) || (state_q == StDone);
    assign out       = out_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_calculator_core.sv
// Testbench for calculator_core: directed cases plus randomized operations on
// an 8-bit instance, and div/mul cases on a 16-bit instance, all checked
// against an arithmetic reference model.
module tb_calculator_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit instance
    logic        in_valid, in_ready, out_valid, out_ready, err_out, busy;
    logic [7:0]  dat_a, dat_b;
    logic [2:0]  fn;
    logic [15:0] out;

    // 16-bit instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16, err_out16, busy16;
    logic [15:0] dat_a16, dat_b16;
    logic [2:0]  fn16;
    logic [31:0] out16;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] last_out;

    calculator_core #(.DATA_W(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dat_a_in   (dat_a),
        .dat_b_in   (dat_b),
        .function_in(fn),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .err_out    (err_out),
        .busy       (busy)
    );

    calculator_core #(.DATA_W(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid16),
        .in_ready   (in_ready16),
        .dat_a_in   (dat_a16),
        .dat_b_in   (dat_b16),
        .function_in(fn16),
        .out_valid  (out_valid16),
        .out_ready  (out_ready16),
        .out        (out16),
        .err_out    (err_out16),
        .busy       (busy16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on wide integers, masked to 2*w bits.
    function automatic logic [63:0] ref_out(input int unsigned w, input longint unsigned a,
                                            input longint unsigned b, input logic [2:0] op);
        longint unsigned mask;
        mask = (64'd1 << (2 * w)) - 64'd1;
        case (op)
            3'd0:    return (a + b) & mask;
            3'd1:    return (a - b) & mask;
            3'd2:    return (a * b) & mask;
            3'd3:    return (b == 0) ? mask : a / b;
            3'd4:    return (b == 0) ? mask : a % b;
            3'd5:    return a & b;
            3'd6:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic ref_err(input longint unsigned b, input logic [2:0] op);
        return (op == 3'd3 || op == 3'd4) && (b == 0);
    endfunction

    function automatic int ref_lat(input int unsigned w, input longint unsigned b,
                                   input logic [2:0] op);
        return ((op == 3'd3 || op == 3'd4) && (b != 0)) ? int'(w) + 1 : 1;
    endfunction

    // Issue one request on the 8-bit core, wait for its result, hold it under
    // backpressure for `hold` cycles, then complete the output handshake.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input int hold);
        int          lat;
        logic [15:0] exp;
        exp = 16'(ref_out(8, a, b, op));
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        dat_a    = a;
        dat_b    = b;
        fn       = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 64) begin
            check("in_ready_calc", in_ready, 0);
            // Operands wander while computing; the result must not follow them.
            dat_a = 8'($urandom);
            dat_b = 8'($urandom);
            fn    = 3'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(ref_lat(8, b, op)));
        check("out", out, exp);
        check("err", err_out, ref_err(b, op));
        check("busy_done", busy, 1);
        check("in_ready_done", in_ready, 0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_out", out, exp);
            check("hold_err", err_out, ref_err(b, op));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check("out_kept", out, exp);
        last_out = out;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        int lat;
        @(negedge clk);
        check("w16_in_ready", in_ready16, 1);
        in_valid16 = 1'b1;
        dat_a16    = a;
        dat_b16    = b;
        fn16       = op;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        lat        = 1;
        while (!out_valid16 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w16_latency", 64'(lat), 64'(ref_lat(16, b, op)));
        check("w16_out", out16, ref_out(16, a, b, op));
        check("w16_err", err_out16, ref_err(b, op));
        out_ready16 = 1'b1;
        @(posedge clk);
        #1;
        out_ready16 = 1'b0;
        check("w16_valid_drop", out_valid16, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a, b;
        logic [2:0] op;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        dat_a       = '0;
        dat_b       = '0;
        fn          = '0;
        in_valid16  = 1'b0;
        out_ready16 = 1'b0;
        dat_a16     = '0;
        dat_b16     = '0;
        fn16        = '0;
        last_out    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_err", err_out, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Directed cases from the plan.
        run8(8'hFF, 8'h01, 3'd0, 0);
        check("plan_add", last_out, 16'h0100);
        run8(8'd5, 8'd7, 3'd1, 0);
        check("plan_sub", last_out, 16'hFFFE);
        run8(8'hFF, 8'hFF, 3'd2, 1);
        check("plan_mul", last_out, 16'hFE01);
        run8(8'hF0, 8'h3C, 3'd7, 0);
        check("plan_xor", last_out, 16'h00CC);
        run8(8'd200, 8'd7, 3'd3, 0);
        check("plan_div", last_out, 16'h001C);
        run8(8'd200, 8'd7, 3'd4, 0);
        check("plan_mod", last_out, 16'h0004);
        run8(8'd7, 8'd200, 3'd3, 0);
        check("plan_div_small", last_out, 16'h0000);
        run8(8'd7, 8'd200, 3'd4, 0);
        check("plan_mod_small", last_out, 16'h0007);
        run8(8'h55, 8'h00, 3'd3, 2);
        check("plan_div0", last_out, 16'hFFFF);
        run8(8'd1, 8'd1, 3'd0, 0);
        check("plan_after_div0", last_out, 16'h0002);

        // Backpressure with the next request already waiting on the input.
        @(negedge clk);
        in_valid = 1'b1;
        dat_a    = 8'h12;
        dat_b    = 8'h34;
        fn       = 3'd2;
        @(posedge clk);
        #1;
        dat_a = 8'h0F;
        dat_b = 8'h01;
        fn    = 3'd0;
        repeat (5) begin
            check("bp_valid", out_valid, 1);
            check("bp_out", out, 16'h03A8);
            check("bp_err", err_out, 0);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        check("bp_release_out", out, 16'h03A8);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_out", out, 16'h0010);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a divide.
        @(negedge clk);
        in_valid = 1'b1;
        dat_a    = 8'd200;
        dat_b    = 8'd3;
        fn       = 3'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_out", out, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err_out, 0);
        run8(8'd100, 8'd10, 3'd3, 0);
        check("after_rst_div", last_out, 16'd10);

        // Randomized operations, biased towards edge operand values.
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 8'h00;
                1:       a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       b = 8'h00;
                1:       b = 8'hFF;
                2:       b = 8'h01;
                default: b = 8'($urandom);
            endcase
            run8(a, b, op, int'($urandom_range(0, 2)));
        end

        // Wider instance.
        run16(16'hFFFF, 16'hFFFF, 3'd2);
        run16(16'd50000, 16'd7, 3'd3);
        run16(16'd50000, 16'd7, 3'd4);
        run16(16'h1234, 16'h0000, 3'd4);
        for (int i = 0; i < 10; i++) begin
            run16(16'($urandom), 16'($urandom_range(1, 65535)), 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/calculator_core.md
Name: calculator_core

Overview:
- Parametrised, handshaked successor to the 8-bit, 4-function calculator DUT.
- Accepts one operation per transaction on a valid/ready input channel and returns a registered result on a valid/ready output channel with backpressure.
- Supports 8 functions; divide and modulo are iterative (multi-cycle).
- Sits between the stimulus-side request channel and the result consumer; the verification environment drives it through an updated calculator interface.

Parameters:
- DATA_W, 8, operand width in bits (supported range 2..32).
- OUT_W, 2*DATA_W, result width. Derived; must not be overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  core can accept a request.
- dat_a_in  input  DATA_W  operand A, unsigned.
- dat_b_in  input  DATA_W  operand B, unsigned.
- function_in  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 and, 110 or, 111 xor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  OUT_W  result.
- err_out  output  1  divide-by-zero flag; qualified by out_valid.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge): state=IDLE, out=0, out_valid=0, err_out=0, busy=0, in_ready=1 from the following cycle. Any division in progress is aborted and its result discarded.
- FSM states:
  - IDLE: in_ready=1. Accept when in_valid && in_ready; operands and opcode are captured on that edge.
  - On accept of a non-div/mod opcode: compute combinationally from the inputs, register into out, go to DONE. out_valid rises the next cycle (latency 1).
  - On accept of div/mod with B!=0: load the remainder register, quotient register and cnt=DATA_W, then go to CALC.
  - On accept of div/mod with B==0: out={OUT_W{1}}, err_out=1, go to DONE (latency 1, no iteration).
  - CALC: one restoring-division step per cycle, MSB first; cnt decrements each cycle. When cnt reaches 1, the final step writes out (quotient for div, remainder for mod, zero-extended) and the FSM goes to DONE. out_valid rises DATA_W+1 cycles after accept (9 for DATA_W=8).
  - DONE: out_valid=1. out and err_out hold stable while out_ready=0. When out_ready=1, the FSM goes to IDLE and out_valid=0 next cycle; out keeps its last value.
- in_ready=0 in CALC and DONE. A request presented then is not accepted and must be held by the source.
- Peak throughput: one result every 2 cycles. No bypass from DONE to accept.
- Arithmetic (all operands unsigned, result OUT_W bits):
  - add: zero-extended sum; carry appears at bit DATA_W.
  - sub: (A-B) mod 2^OUT_W, i.e. a negative result is sign-extended two's complement.
  - mul: full unsigned product, no truncation.
  - div: floor(A/B). mod: A mod B.
  - and/or/xor: bitwise, zero-extended.
- err_out=1 only for a divide-by-zero result. It is cleared on the next accepted request and on reset.
- Stability: inputs are sampled only on the accept edge; changes to dat_a_in/dat_b_in/function_in during CALC have no effect.
- Simultaneous reset and handshake: reset wins; no transaction completes.

Test Plan:
- Reset then add: A=8'hFF, B=8'h01 -> out=16'h0100, err_out=0, out_valid one cycle after accept; in_ready low until out_ready handshake completes.
- Sub/mul/logic: A=5, B=7 sub -> 16'hFFFE; A=8'hFF, B=8'hFF mul -> 16'hFE01; A=8'hF0, B=8'h3C xor -> 16'h00CC.
- Div/mod: A=200, B=7 div -> out=16'h001C with out_valid exactly 9 cycles after accept; mod -> 16'h0004; A=7, B=200 div -> 0, mod -> 7.
- Divide by zero: A=8'h55, B=0, div -> out=16'hFFFF, err_out=1 at latency 1; next request (add 1+1) -> out=2, err_out=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out, err_out, out_valid stable, in_ready=0; in_valid held with new operands is not accepted until the cycle after out_ready=1.
- Reset mid-divide: assert rst_n=0 on cycle 4 of a div -> next cycle out=0, out_valid=0, in_ready=1; a subsequent div 100/10 -> 10 with normal 9-cycle latency. Repeat the div/mul checks at DATA_W=16 (65535*65535 -> 32'hFFFE0001).
